// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Registered MEM/WB pipeline stage. Captures MEM results, selects
//            one of four writeback sources, extracts and extends sub-word
//            loads, flags misaligned loads and drives the register-file
//            write port plus a forwarding view.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int DATA_W           = 32,
  parameter int REG_ADDR_W       = 5,
  parameter int ZERO_REG_WE_MASK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_RFWE,
  input  logic [1:0]            in_WBSel,
  input  logic [1:0]            in_LdSize,
  input  logic                  in_LdSigned,
  input  logic [REG_ADDR_W-1:0] in_rtd,
  input  logic [DATA_W-1:0]     in_ALUOut,
  input  logic [DATA_W-1:0]     in_DMOut,
  input  logic [DATA_W-1:0]     in_PCPlus4,
  input  logic [DATA_W-1:0]     in_Imm,
  output logic                  out_valid,
  output logic                  out_RFWE,
  output logic [REG_ADDR_W-1:0] out_rtd,
  output logic [DATA_W-1:0]     out_RFWD,
  output logic                  out_misalign,
  output logic                  fwd_valid
);

  // Number of address bits selecting a byte lane within one data word.
  localparam int LANE_W = $clog2(DATA_W / 8);
  localparam bit MASK_R0 = (ZERO_REG_WE_MASK != 0);

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_LD  = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  logic                  valid_q,    valid_d;
  logic                  rfwe_q,     rfwe_d;
  logic [1:0]            wbsel_q,    wbsel_d;
  logic [1:0]            ldsize_q,   ldsize_d;
  logic                  ldsigned_q, ldsigned_d;
  logic [REG_ADDR_W-1:0] rtd_q,      rtd_d;
  logic [DATA_W-1:0]     aluout_q,   aluout_d;
  logic [DATA_W-1:0]     dmout_q,    dmout_d;
  logic [DATA_W-1:0]     pcplus4_q,  pcplus4_d;
  logic [DATA_W-1:0]     imm_q,      imm_d;

  logic [LANE_W-1:0]     addr;
  logic [7:0]            byte_f;
  logic [15:0]           half_f;
  logic [DATA_W-1:0]     word_ext;
  logic [DATA_W-1:0]     ld_val;
  logic                  misalign;

  // Next stage contents: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    valid_d    = valid_q;
    rfwe_d     = rfwe_q;
    wbsel_d    = wbsel_q;
    ldsize_d   = ldsize_q;
    ldsigned_d = ldsigned_q;
    rtd_d      = rtd_q;
    aluout_d   = aluout_q;
    dmout_d    = dmout_q;
    pcplus4_d  = pcplus4_q;
    imm_d      = imm_q;
    if (flush) begin
      valid_d    = 1'b0;
      rfwe_d     = 1'b0;
      wbsel_d    = '0;
      ldsize_d   = '0;
      ldsigned_d = 1'b0;
      rtd_d      = '0;
      aluout_d   = '0;
      dmout_d    = '0;
      pcplus4_d  = '0;
      imm_d      = '0;
    end else if (!stall) begin
      valid_d    = in_valid;
      rfwe_d     = in_RFWE;
      wbsel_d    = in_WBSel;
      ldsize_d   = in_LdSize;
      ldsigned_d = in_LdSigned;
      rtd_d      = in_rtd;
      aluout_d   = in_ALUOut;
      dmout_d    = in_DMOut;
      pcplus4_d  = in_PCPlus4;
      imm_d      = in_Imm;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rfwe_q     <= 1'b0;
      wbsel_q    <= '0;
      ldsize_q   <= '0;
      ldsigned_q <= 1'b0;
      rtd_q      <= '0;
      aluout_q   <= '0;
      dmout_q    <= '0;
      pcplus4_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rfwe_q     <= rfwe_d;
      wbsel_q    <= wbsel_d;
      ldsize_q   <= ldsize_d;
      ldsigned_q <= ldsigned_d;
      rtd_q      <= rtd_d;
      aluout_q   <= aluout_d;
      dmout_q    <= dmout_d;
      pcplus4_q  <= pcplus4_d;
      imm_q      <= imm_d;
    end
  end

  // Little-endian lane extraction; the halfword lane drops the low address bit.
  assign addr   = aluout_q[LANE_W-1:0];
  assign byte_f = dmout_q[{addr, 3'b000} +: 8];
  assign half_f = dmout_q[{addr[LANE_W-1:1], 4'b0000} +: 16];

  // Word loads take the low 32 bits; only a 64-bit datapath needs extension.
  generate
    if (DATA_W > 32) begin : g_word_wide
      assign word_ext = {{(DATA_W-32){ldsigned_q & dmout_q[31]}}, dmout_q[31:0]};
    end else begin : g_word_narrow
      assign word_ext = dmout_q;
    end
  endgenerate

  // Load value, misalignment and writeback-source select.
  always_comb begin
    ld_val   = word_ext;
    misalign = 1'b0;
    out_RFWD = aluout_q;
    case (ldsize_q)
      LD_BYTE: ld_val = {{(DATA_W-8){ldsigned_q & byte_f[7]}}, byte_f};
      LD_HALF: ld_val = {{(DATA_W-16){ldsigned_q & half_f[15]}}, half_f};
      default: ld_val = word_ext;
    endcase
    case (wbsel_q)
      WB_ALU: out_RFWD = aluout_q;
      WB_LD: begin
        out_RFWD = ld_val;
        if (ldsize_q == LD_HALF)
          misalign = addr[0];
        else if (ldsize_q != LD_BYTE)
          misalign = (addr[1:0] != 2'b00);
      end
      WB_PC:   out_RFWD = pcplus4_q;
      WB_IMM:  out_RFWD = imm_q;
      default: out_RFWD = aluout_q;
    endcase
  end

  assign out_valid    = valid_q;
  assign out_rtd      = rtd_q;
  assign out_misalign = misalign;
  assign out_RFWE     = valid_q & rfwe_q & ~misalign & ~(MASK_R0 & (rtd_q == '0));
  assign fwd_valid    = out_valid & out_RFWE;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage: directed vector table,
//            hand-written stall/flush/reset sequences and randomized traffic
//            checked against a behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  typedef struct {
    bit          valid;
    bit          rfwe;
    bit   [1:0]  wbsel;
    bit   [1:0]  ldsize;
    bit          ldsigned;
    bit   [4:0]  rtd;
    bit   [31:0] alu;
    bit   [31:0] dm;
    bit   [31:0] pc;
    bit   [31:0] imm;
  } mem_t;

  typedef struct {
    mem_t        m;
    bit   [31:0] rfwd;
    bit          rfwe;
    bit          mis;
    bit          valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_RFWE = 1'b0;
  logic [1:0]  in_WBSel = '0;
  logic [1:0]  in_LdSize = '0;
  logic        in_LdSigned = 1'b0;
  logic [4:0]  in_rtd = '0;
  logic [31:0] in_ALUOut = '0;
  logic [31:0] in_DMOut = '0;
  logic [31:0] in_PCPlus4 = '0;
  logic [31:0] in_Imm = '0;
  logic        out_valid;
  logic        out_RFWE;
  logic [4:0]  out_rtd;
  logic [31:0] out_RFWD;
  logic        out_misalign;
  logic        fwd_valid;

  int   n_cmp  = 0;
  int   n_fail = 0;
  mem_t model;
  vec_t tbl[13];

  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_WE_MASK(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RFWE(in_RFWE), .in_WBSel(in_WBSel),
    .in_LdSize(in_LdSize), .in_LdSigned(in_LdSigned), .in_rtd(in_rtd),
    .in_ALUOut(in_ALUOut), .in_DMOut(in_DMOut), .in_PCPlus4(in_PCPlus4),
    .in_Imm(in_Imm), .out_valid(out_valid), .out_RFWE(out_RFWE),
    .out_rtd(out_rtd), .out_RFWD(out_RFWD), .out_misalign(out_misalign),
    .fwd_valid(fwd_valid)
  );

  always #5 clk = ~clk;

  function automatic mem_t mk(bit v, bit rf, bit [1:0] ws, bit [1:0] ls, bit sg,
                              bit [4:0] rd, bit [31:0] alu, bit [31:0] dm,
                              bit [31:0] pc, bit [31:0] imm);
    mem_t r;
    r.valid = v; r.rfwe = rf; r.wbsel = ws; r.ldsize = ls; r.ldsigned = sg;
    r.rtd = rd; r.alu = alu; r.dm = dm; r.pc = pc; r.imm = imm;
    return r;
  endfunction

  // Reference: what the register file should see for a given stage content.
  task automatic expect_of(input mem_t s, output bit [31:0] rfwd,
                           output bit rfwe, output bit mis);
    longint unsigned a, v;
    a   = s.alu % 4;
    mis = 1'b0;
    v   = s.dm;
    if (s.ldsize == 2'd2) begin
      v = (s.dm >> (8 * a)) % 256;
      if (s.ldsigned && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (s.ldsize == 2'd1) begin
      v = (s.dm >> (16 * (a / 2))) % 65536;
      if (s.ldsigned && v >= 32768) v = v + 64'hFFFF_0000;
    end
    case (s.wbsel)
      2'd0: rfwd = s.alu;
      2'd1: begin
        rfwd = v[31:0];
        if (s.ldsize == 2'd1)      mis = (a % 2) != 0;
        else if (s.ldsize != 2'd2) mis = (a != 0);
      end
      2'd2: rfwd = s.pc;
      default: rfwd = s.imm;
    endcase
    rfwe = s.valid && s.rfwe && !mis && (s.rtd != 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    bit [31:0] e_rfwd;
    bit        e_rfwe, e_mis;
    expect_of(model, e_rfwd, e_rfwe, e_mis);
    chk({tag, ".rfwd"},  out_RFWD,     e_rfwd);
    chk({tag, ".rfwe"},  {31'd0, out_RFWE},     {31'd0, e_rfwe});
    chk({tag, ".mis"},   {31'd0, out_misalign}, {31'd0, e_mis});
    chk({tag, ".valid"}, {31'd0, out_valid},    {31'd0, model.valid});
    chk({tag, ".fwd"},   {31'd0, fwd_valid},    {31'd0, e_rfwe});
    chk({tag, ".rtd"},   {27'd0, out_rtd},      {27'd0, model.rtd});
  endtask

  // Drive on the falling edge, advance the model at the rising edge, settle.
  task automatic step(input mem_t m, input bit st, input bit fl);
    @(negedge clk);
    in_valid = m.valid; in_RFWE = m.rfwe; in_WBSel = m.wbsel;
    in_LdSize = m.ldsize; in_LdSigned = m.ldsigned; in_rtd = m.rtd;
    in_ALUOut = m.alu; in_DMOut = m.dm; in_PCPlus4 = m.pc; in_Imm = m.imm;
    stall = st; flush = fl;
    @(posedge clk);
    if (fl)       model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    else if (!st) model = m;
    #1;
  endtask

  function automatic mem_t rnd_mem();
    mem_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.rfwe = ($urandom_range(0, 5) != 0);
    r.wbsel = 2'($urandom); r.ldsize = 2'($urandom); r.ldsigned = 1'($urandom);
    r.rtd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    r.alu = $urandom; r.dm = $urandom; r.pc = $urandom; r.imm = $urandom;
    return r;
  endfunction

  initial begin
    mem_t a;
    model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed vectors with hand-derived expectations.
    tbl[0]  = '{m: mk(1,1,2'd0,2'd0,0,5'd8,32'h0000_1234,32'h0,32'h0,32'h0), rfwd: 32'h0000_1234, rfwe: 1, mis: 0, valid: 1};
    tbl[1]  = '{m: mk(1,1,2'd1,2'd2,1,5'd5,32'h0000_0003,32'h80FF_7F01,32'h0,32'h0), rfwd: 32'hFFFF_FF80, rfwe: 1, mis: 0, valid: 1};
    tbl[2]  = '{m: mk(1,1,2'd1,2'd2,0,5'd5,32'h0000_0003,32'h80FF_7F01,32'h0,32'h0), rfwd: 32'h0000_0080, rfwe: 1, mis: 0, valid: 1};
    tbl[3]  = '{m: mk(1,1,2'd1,2'd2,1,5'd5,32'h0000_0001,32'h80FF_7F01,32'h0,32'h0), rfwd: 32'h0000_007F, rfwe: 1, mis: 0, valid: 1};
    tbl[4]  = '{m: mk(1,1,2'd1,2'd1,1,5'd6,32'h0000_0002,32'h8001_FFFE,32'h0,32'h0), rfwd: 32'hFFFF_8001, rfwe: 1, mis: 0, valid: 1};
    tbl[5]  = '{m: mk(1,1,2'd1,2'd1,1,5'd6,32'h0000_0001,32'h8001_FFFE,32'h0,32'h0), rfwd: 32'hFFFF_FFFE, rfwe: 0, mis: 1, valid: 1};
    tbl[6]  = '{m: mk(1,1,2'd2,2'd0,0,5'd1,32'h0,32'h0,32'h0040_0008,32'h0), rfwd: 32'h0040_0008, rfwe: 1, mis: 0, valid: 1};
    tbl[7]  = '{m: mk(1,1,2'd3,2'd0,0,5'd0,32'h0,32'h0,32'h0,32'hABCD_0000), rfwd: 32'hABCD_0000, rfwe: 0, mis: 0, valid: 1};
    tbl[8]  = '{m: mk(1,1,2'd1,2'd0,0,5'd9,32'h0000_0102,32'h1234_5678,32'h0,32'h0), rfwd: 32'h1234_5678, rfwe: 0, mis: 1, valid: 1};
    tbl[9]  = '{m: mk(1,1,2'd1,2'd3,1,5'd9,32'h0000_0004,32'h1234_5678,32'h0,32'h0), rfwd: 32'h1234_5678, rfwe: 1, mis: 0, valid: 1};
    tbl[10] = '{m: mk(0,1,2'd0,2'd0,0,5'd7,32'hDEAD_BEEF,32'h0,32'h0,32'h0), rfwd: 32'hDEAD_BEEF, rfwe: 0, mis: 0, valid: 0};
    tbl[11] = '{m: mk(1,1,2'd1,2'd1,0,5'd3,32'h0000_0000,32'h8001_FFFE,32'h0,32'h0), rfwd: 32'h0000_FFFE, rfwe: 1, mis: 0, valid: 1};
    tbl[12] = '{m: mk(1,1,2'd0,2'd1,0,5'd4,32'h0000_0003,32'h0,32'h0,32'h0), rfwd: 32'h0000_0003, rfwe: 1, mis: 0, valid: 1};

    // Asynchronous reset between edges clears everything immediately.
    #1 rst = 1'b1;
    #2 chk_model("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].m, 1'b0, 1'b0);
      chk($sformatf("vec%0d.rfwd", i),  out_RFWD,                   tbl[i].rfwd);
      chk($sformatf("vec%0d.rfwe", i),  {31'd0, out_RFWE},          {31'd0, tbl[i].rfwe});
      chk($sformatf("vec%0d.mis", i),   {31'd0, out_misalign},      {31'd0, tbl[i].mis});
      chk($sformatf("vec%0d.valid", i), {31'd0, out_valid},         {31'd0, tbl[i].valid});
      chk($sformatf("vec%0d.fwd", i),   {31'd0, fwd_valid},         {31'd0, tbl[i].rfwe});
      chk($sformatf("vec%0d.rtd", i),   {27'd0, out_rtd},           {27'd0, tbl[i].m.rtd});
    end

    // Stall for three cycles with changing inputs: outputs frozen.
    step(tbl[1].m, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(rnd_mem(), 1'b1, 1'b0);
      chk_model("stall");
      chk("stall.frozen", out_RFWD, 32'hFFFF_FF80);
    end

    // Flush wins over simultaneous stall.
    step(tbl[0].m, 1'b1, 1'b1);
    chk_model("flush_stall");
    chk("flush_stall.valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall: immediate clear, then normal capture after release.
    step(tbl[4].m, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b1;
    #2 rst = 1'b1;
    model = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_model("midreset");
    @(negedge clk) rst = 1'b0;
    step(tbl[6].m, 1'b0, 1'b0);
    chk_model("post_reset");
    chk("post_reset.rfwd", out_RFWD, 32'h0040_0008);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      a = rnd_mem();
      if (($urandom % 4) == 0) a.alu[1:0] = 2'b00;
      step(a, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
